// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles every handshake and bus signal around the shared ALU arbiter.
//   r0_* / r1_* : requester valid/ready handshakes, ALUOp and operands
//   alu_*       : operation driven to the combinational alu and its result
//   resp_*      : held response channel (valid/ready, id, result, taken, err)
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding system (requesters, alu, response consumer)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int DW  = 8,
  parameter int OPW = 3
);
  logic           r0_valid;
  logic           r0_ready;
  logic [OPW-1:0] r0_op;
  logic [DW-1:0]  r0_a;
  logic [DW-1:0]  r0_b;

  logic           r1_valid;
  logic           r1_ready;
  logic [OPW-1:0] r1_op;
  logic [DW-1:0]  r1_a;
  logic [DW-1:0]  r1_b;

  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_rslt;
  logic           alu_taken;

  logic           resp_valid;
  logic           resp_ready;
  logic           resp_id;
  logic [DW-1:0]  resp_rslt;
  logic           resp_taken;
  logic           resp_err;

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b,
    output r0_ready,
    input  r1_valid, r1_op, r1_a, r1_b,
    output r1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_rslt, alu_taken,
    output resp_valid, resp_id, resp_rslt, resp_taken, resp_err,
    input  resp_ready
  );

  modport master (
    output r0_valid, r0_op, r0_a, r0_b,
    input  r0_ready,
    output r1_valid, r1_op, r1_a, r1_b,
    input  r1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_rslt, alu_taken,
    input  resp_valid, resp_id, resp_rslt, resp_taken, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational 8-bit alu between two requesters using round-robin
// arbitration. An accepted op is registered onto the alu inputs, the alu result
// is captured one cycle later, and a held response is offered on resp_*.
// Ports:
//   i_clk     : clock, all state updates on the rising edge
//   i_reset_n : synchronous active-low reset
//   io_bus    : alu_arbiter_if.slave (requesters, alu, response channel)
//   o_busy    : high whenever the FSM is not IDLE
// Optional feature: define ALU_OPCHECK_EN to reject ops 000/110/111 with an
// immediate error response instead of issuing them to the alu.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DW  = 8,
  parameter int OPW = 3
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  alu_arbiter_if.slave  io_bus,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_ptr;        // requester favoured when both are valid
  logic           r_id;         // requester of the op currently in EXEC
  logic [OPW-1:0] r_alu_op;
  logic [DW-1:0]  r_alu_a;
  logic [DW-1:0]  r_alu_b;
  logic           r_resp_valid;
  logic           r_resp_id;
  logic [DW-1:0]  r_resp_rslt;
  logic           r_resp_taken;
  logic           r_resp_err;
  logic           r_busy;

  logic           w_idle;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_accept;
  logic           w_sel;
  logic [OPW-1:0] w_op;
  logic [DW-1:0]  w_a;
  logic [DW-1:0]  w_b;
  logic           w_illegal;

  // Grant only in IDLE; a lone valid always wins, a tie goes to the pointer.
  assign w_idle   = (r_state == S_IDLE);
  assign w_gnt0   = w_idle && io_bus.r0_valid && (!io_bus.r1_valid || !r_ptr);
  assign w_gnt1   = w_idle && io_bus.r1_valid && (!io_bus.r0_valid ||  r_ptr);
  assign w_accept = w_gnt0 || w_gnt1;
  assign w_sel    = w_gnt1;

  assign w_op = w_sel ? io_bus.r1_op : io_bus.r0_op;
  assign w_a  = w_sel ? io_bus.r1_a  : io_bus.r0_a;
  assign w_b  = w_sel ? io_bus.r1_b  : io_bus.r0_b;

`ifdef ALU_OPCHECK_EN
  assign w_illegal = (w_op == OPW'(0)) || (w_op == OPW'(6)) || (w_op == OPW'(7));
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= 1'b0;
      r_id         <= 1'b0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_rslt  <= '0;
      r_resp_taken <= 1'b0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id   <= w_sel;
            r_ptr  <= ~w_sel;
            r_busy <= 1'b1;
            if (w_illegal) begin
              // Rejected op skips the alu entirely; alu_* keep their old values.
              r_resp_valid <= 1'b1;
              r_resp_id    <= w_sel;
              r_resp_rslt  <= '0;
              r_resp_taken <= 1'b0;
              r_resp_err   <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_alu_op <= w_op;
              r_alu_a  <= w_a;
              r_alu_b  <= w_b;
              r_state  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_resp_rslt  <= io_bus.alu_rslt;
          r_resp_taken <= io_bus.alu_taken;
          r_resp_id    <= r_id;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (io_bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.r0_ready   = w_gnt0;
  assign io_bus.r1_ready   = w_gnt1;
  assign io_bus.alu_op     = r_alu_op;
  assign io_bus.alu_a      = r_alu_a;
  assign io_bus.alu_b      = r_alu_b;
  assign io_bus.resp_valid = r_resp_valid;
  assign io_bus.resp_id    = r_resp_id;
  assign io_bus.resp_rslt  = r_resp_rslt;
  assign io_bus.resp_taken = r_resp_taken;
  assign io_bus.resp_err   = r_resp_err;
  assign o_busy            = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Drives both requesters and the response consumer, models the external alu,
// and scores every response against expectations queued at grant time.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int DW  = 8;
  localparam int OPW = 3;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] rslt;
    logic          taken;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DW(DW), .OPW(OPW)) bus ();

  alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .io_bus    (bus),
    .o_busy    (busy)
  );

  // External alu model: {taken, rslt}; taken flags a zero result.
  function automatic logic [DW:0] alu_fn(input logic [OPW-1:0] op,
                                         input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a + b;
      3'b010:  r = a - b;
      3'b011:  r = a ^ b;
      3'b100:  r = a | b;
      3'b101:  r = (a < b) ? DW'(1) : DW'(0);
      3'b110:  r = ~(a | b);
      default: r = b;
    endcase
    return {(r == '0), r};
  endfunction

  assign {bus.alu_taken, bus.alu_rslt} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  function automatic exp_t mk_exp(input logic id, input logic [OPW-1:0] op,
                                  input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    logic [DW:0] v;
    v       = alu_fn(op, a, b);
    e.id    = id;
    e.rslt  = v[DW-1:0];
    e.taken = v[DW];
    e.err   = 1'b0;
    return e;
  endfunction

  task automatic idle_inputs();
    bus.r0_valid = 1'b0; bus.r0_op = '0; bus.r0_a = '0; bus.r0_b = '0;
    bus.r1_valid = 1'b0; bus.r1_op = '0; bus.r1_a = '0; bus.r1_b = '0;
    bus.resp_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b want=0", busy);
    end
    checks++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 19'h0) begin
      failures++; $display("FAIL reset_alu got=%h want=0", {bus.alu_op, bus.alu_a, bus.alu_b});
    end
    checks++;
    if ({bus.resp_id, bus.resp_rslt, bus.resp_taken, bus.resp_err} !== 11'h0) begin
      failures++; $display("FAIL reset_resp got=%h want=0",
                           {bus.resp_id, bus.resp_rslt, bus.resp_taken, bus.resp_err});
    end
    $display("txn reset done");
    rst_n = 1'b1;
  endtask

  task automatic test_only_r1();
    exp_t e, got;
    @(negedge clk);
    bus.r1_valid = 1'b1; bus.r1_op = 3'b011; bus.r1_a = 8'h3C; bus.r1_b = 8'h0F;
    #1;
    checks++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b01) begin
      failures++; $display("FAIL only_r1_grant got=%b want=01", {bus.r0_ready, bus.r1_ready});
    end
    sb_q.push_back(mk_exp(1'b1, 3'b011, 8'h3C, 8'h0F));
    @(negedge clk);
    bus.r1_valid = 1'b0;
    #1;
    checks++;
    if ({busy, bus.resp_valid} !== 2'b10) begin
      failures++; $display("FAIL only_r1_exec busy_rv got=%b want=10", {busy, bus.resp_valid});
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b1 || sb_q.size() == 0) begin
      failures++; $display("FAIL only_r1_latency resp_valid got=%b want=1", bus.resp_valid);
    end else begin
      e   = sb_q.pop_front();
      got = {bus.resp_id, bus.resp_rslt, bus.resp_taken, bus.resp_err};
      if (got !== e) begin
        failures++; $display("FAIL only_r1_resp got=%h want=%h", got, e);
      end
      $display("txn resp id=%0d rslt=%h taken=%b", bus.resp_id, bus.resp_rslt, bus.resp_taken);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, bus.resp_valid} !== 2'b00) begin
      failures++; $display("FAIL only_r1_idle busy_rv got=%b want=00", {busy, bus.resp_valid});
    end
    // Pointer must now favour r0: raise both and withdraw before the edge.
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      failures++; $display("FAIL only_r1_ptr got=%b want=10", {bus.r0_ready, bus.r1_ready});
    end
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
  endtask

  task automatic test_single_r0();
    exp_t e, got;
    @(negedge clk);
    bus.r0_valid = 1'b1; bus.r0_op = 3'b001; bus.r0_a = 8'hA0; bus.r0_b = 8'h06;
    bus.resp_ready = 1'b1;
    #1;
    checks++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      failures++; $display("FAIL single_grant got=%b want=10", {bus.r0_ready, bus.r1_ready});
    end
    sb_q.push_back(mk_exp(1'b0, 3'b001, 8'hA0, 8'h06));
    @(negedge clk);
    bus.r0_valid = 1'b0;
    #1;
    checks++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {3'b001, 8'hA0, 8'h06}) begin
      failures++; $display("FAIL single_alu_drive got=%h want=%h",
                           {bus.alu_op, bus.alu_a, bus.alu_b}, {3'b001, 8'hA0, 8'h06});
    end
    checks++;
    if ({busy, bus.resp_valid} !== 2'b10) begin
      failures++; $display("FAIL single_exec busy_rv got=%b want=10", {busy, bus.resp_valid});
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b1 || sb_q.size() == 0) begin
      failures++; $display("FAIL single_latency resp_valid got=%b want=1", bus.resp_valid);
    end else begin
      e   = sb_q.pop_front();
      got = {bus.resp_id, bus.resp_rslt, bus.resp_taken, bus.resp_err};
      if (got !== e) begin
        failures++; $display("FAIL single_resp got=%h want=%h", got, e);
      end
      $display("txn resp id=%0d rslt=%h taken=%b", bus.resp_id, bus.resp_rslt, bus.resp_taken);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, bus.resp_valid} !== 2'b00) begin
      failures++; $display("FAIL single_idle busy_rv got=%b want=00", {busy, bus.resp_valid});
    end
    checks++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {3'b001, 8'hA0, 8'h06}) begin
      failures++; $display("FAIL single_alu_hold got=%h want=%h",
                           {bus.alu_op, bus.alu_a, bus.alu_b}, {3'b001, 8'hA0, 8'h06});
    end
  endtask

  task automatic test_reset_mid();
    // Pointer is 1 here (last grant went to r0).
    @(negedge clk);
    bus.r1_valid = 1'b1; bus.r1_op = 3'b100; bus.r1_a = 8'h11; bus.r1_b = 8'h90;
    #1;
    checks++;
    if (bus.r1_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_grant r1_ready got=%b want=1", bus.r1_ready);
    end
    sb_q.push_back(mk_exp(1'b1, 3'b100, 8'h11, 8'h90));
    @(negedge clk);
    bus.r1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_exec busy got=%b want=1", busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, bus.resp_valid} !== 2'b00) begin
      failures++; $display("FAIL rstmid_after busy_rv got=%b want=00", {busy, bus.resp_valid});
    end
    checks++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 19'h0) begin
      failures++; $display("FAIL rstmid_alu got=%h want=0", {bus.alu_op, bus.alu_a, bus.alu_b});
    end
    rst_n = 1'b1;
    sb_q.delete();
    $display("txn reset mid-op, in-flight op discarded");
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      failures++; $display("FAIL rstmid_ptr got=%b want=10", {bus.r0_ready, bus.r1_ready});
    end
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_no_resp resp_valid got=%b want=0", bus.resp_valid);
    end
  endtask

  task automatic test_fairness();
    int   gnt_ids[$];
    int   gnt_cyc[$];
    exp_t e, got;
    bus.resp_ready = 1'b1;
    bus.r0_op = 3'b010; bus.r0_a = 8'h11; bus.r0_b = 8'h90;
    bus.r1_op = 3'b011; bus.r1_a = 8'h01; bus.r1_b = 8'h00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt_ids.size() >= 3) begin
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
      end else begin
        bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
      end
      #1;
      if (bus.r0_ready) begin
        sb_q.push_back(mk_exp(1'b0, 3'b010, 8'h11, 8'h90));
        gnt_ids.push_back(0); gnt_cyc.push_back(c);
        $display("txn grant r0 cycle=%0d", c);
      end
      if (bus.r1_ready) begin
        sb_q.push_back(mk_exp(1'b1, 3'b011, 8'h01, 8'h00));
        gnt_ids.push_back(1); gnt_cyc.push_back(c);
        $display("txn grant r1 cycle=%0d", c);
      end
      if (bus.resp_valid && bus.resp_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++; $display("FAIL fair_resp_unexpected got_id=%0d want=none", bus.resp_id);
        end else begin
          e   = sb_q.pop_front();
          got = {bus.resp_id, bus.resp_rslt, bus.resp_taken, bus.resp_err};
          if (got !== e) begin
            failures++; $display("FAIL fair_resp got=%h want=%h", got, e);
          end
          $display("txn resp id=%0d rslt=%h taken=%b", bus.resp_id, bus.resp_rslt, bus.resp_taken);
        end
      end
    end
    checks++;
    if (gnt_ids.size() != 3) begin
      failures++; $display("FAIL fair_grant_count got=%0d want=3", gnt_ids.size());
    end else begin
      checks++;
      if (gnt_ids[0] != 0 || gnt_ids[1] != 1 || gnt_ids[2] != 0) begin
        failures++; $display("FAIL fair_order got=%0d%0d%0d want=010",
                             gnt_ids[0], gnt_ids[1], gnt_ids[2]);
      end
      checks++;
      if (gnt_cyc[1] - gnt_cyc[0] != 3 || gnt_cyc[2] - gnt_cyc[1] != 3) begin
        failures++; $display("FAIL fair_interval got=%0d,%0d want=3,3",
                             gnt_cyc[1] - gnt_cyc[0], gnt_cyc[2] - gnt_cyc[1]);
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL fair_drain pending got=%0d want=0", sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    exp_t e, got;
    // Pointer is 1 after the fairness run; r0 alone still wins.
    @(negedge clk);
    bus.r0_valid = 1'b1; bus.r0_op = 3'b101; bus.r0_a = 8'h05; bus.r0_b = 8'h09;
    bus.resp_ready = 1'b0;
    #1;
    checks++;
    if (bus.r0_ready !== 1'b1) begin
      failures++; $display("FAIL bp_grant r0_ready got=%b want=1", bus.r0_ready);
    end
    sb_q.push_back(mk_exp(1'b0, 3'b101, 8'h05, 8'h09));
    @(negedge clk);
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b1; bus.r1_op = 3'b001; bus.r1_a = 8'h12; bus.r1_b = 8'h34;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bus.resp_valid !== 1'b1 || sb_q.size() == 0 ||
          {bus.resp_id, bus.resp_rslt, bus.resp_taken, bus.resp_err} !== sb_q[0]) begin
        failures++; $display("FAIL bp_hold k=%0d got=%b/%h want=1/%h", k, bus.resp_valid,
                             {bus.resp_id, bus.resp_rslt, bus.resp_taken, bus.resp_err},
                             (sb_q.size() != 0) ? sb_q[0] : exp_t'(0));
      end
      checks++;
      if ({bus.r0_ready, bus.r1_ready, busy} !== 3'b001) begin
        failures++; $display("FAIL bp_stall k=%0d rdy_busy got=%b want=001",
                             k, {bus.r0_ready, bus.r1_ready, busy});
      end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    #1;
    checks++;
    if (bus.r1_ready !== 1'b0) begin
      failures++; $display("FAIL bp_handshake_accept r1_ready got=%b want=0", bus.r1_ready);
    end
    checks++;
    if (bus.resp_valid !== 1'b1 || sb_q.size() == 0) begin
      failures++; $display("FAIL bp_resp_valid got=%b want=1", bus.resp_valid);
    end else begin
      e   = sb_q.pop_front();
      got = {bus.resp_id, bus.resp_rslt, bus.resp_taken, bus.resp_err};
      if (got !== e) begin
        failures++; $display("FAIL bp_resp got=%h want=%h", got, e);
      end
      $display("txn resp id=%0d rslt=%h taken=%b after stall", bus.resp_id, bus.resp_rslt, bus.resp_taken);
    end
    @(negedge clk);
    bus.r1_valid = 1'b0;
    #1;
    checks++;
    if ({busy, bus.resp_valid} !== 2'b00) begin
      failures++; $display("FAIL bp_idle busy_rv got=%b want=00", {busy, bus.resp_valid});
    end
  endtask

  task automatic test_opcheck();
    exp_t e, got;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.r0_valid = 1'b1; bus.r0_op = 3'b111; bus.r0_a = 8'h33; bus.r0_b = 8'h44;
    #1;
    checks++;
    if (bus.r0_ready !== 1'b1) begin
      failures++; $display("FAIL op111_grant r0_ready got=%b want=1", bus.r0_ready);
    end
`ifdef ALU_OPCHECK_EN
    sb_q.push_back(exp_t'{id: 1'b0, rslt: '0, taken: 1'b0, err: 1'b1});
    @(negedge clk);
    bus.r0_valid = 1'b0;
    #1;
    checks++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {3'b101, 8'h05, 8'h09}) begin
      failures++; $display("FAIL op111_alu_unchanged got=%h want=%h",
                           {bus.alu_op, bus.alu_a, bus.alu_b}, {3'b101, 8'h05, 8'h09});
    end
    checks++;
    if (bus.resp_valid !== 1'b1 || sb_q.size() == 0) begin
      failures++; $display("FAIL op111_latency resp_valid got=%b want=1", bus.resp_valid);
    end else begin
      e   = sb_q.pop_front();
      got = {bus.resp_id, bus.resp_rslt, bus.resp_taken, bus.resp_err};
      if (got !== e) begin
        failures++; $display("FAIL op111_resp got=%h want=%h", got, e);
      end
      $display("txn resp id=%0d err=%b (rejected op)", bus.resp_id, bus.resp_err);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, bus.resp_valid} !== 2'b00) begin
      failures++; $display("FAIL op111_idle busy_rv got=%b want=00", {busy, bus.resp_valid});
    end
    // Legal op afterwards takes the normal two-cycle path with err clear.
    @(negedge clk);
    bus.r0_valid = 1'b1; bus.r0_op = 3'b101; bus.r0_a = 8'h00; bus.r0_b = 8'h00;
    #1;
    sb_q.push_back(mk_exp(1'b0, 3'b101, 8'h00, 8'h00));
`else
    sb_q.push_back(mk_exp(1'b0, 3'b111, 8'h33, 8'h44));
`endif
    @(negedge clk);
    bus.r0_valid = 1'b0;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL opchk_exec resp_valid got=%b want=0", bus.resp_valid);
    end
`ifndef ALU_OPCHECK_EN
    checks++;
    if (bus.alu_op !== 3'b111) begin
      failures++; $display("FAIL op111_issued alu_op got=%b want=111", bus.alu_op);
    end
`endif
    @(negedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b1 || sb_q.size() == 0) begin
      failures++; $display("FAIL opchk_latency resp_valid got=%b want=1", bus.resp_valid);
    end else begin
      e   = sb_q.pop_front();
      got = {bus.resp_id, bus.resp_rslt, bus.resp_taken, bus.resp_err};
      if (got !== e) begin
        failures++; $display("FAIL opchk_resp got=%h want=%h", got, e);
      end
      $display("txn resp id=%0d rslt=%h taken=%b err=%b", bus.resp_id, bus.resp_rslt,
               bus.resp_taken, bus.resp_err);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, bus.resp_valid} !== 2'b00) begin
      failures++; $display("FAIL opchk_idle busy_rv got=%b want=00", {busy, bus.resp_valid});
    end
  endtask

  initial begin
    test_reset();
    test_only_r1();
    test_single_r0();
    test_reset_mid();
    test_fairness();
    test_backpressure();
    test_opcheck();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL final_scoreboard pending got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit alu between two requesters (r0, r1) with round-robin arbitration and valid/ready handshakes.
- Drives the alu's ALUOp/inA/inB from registered operands and captures rslt/taken into a held response.
- Sits between the requesters (e.g. control/PC logic and an execute helper) and the combinational alu instance.

Parameters:
- DW, 8, operand/result width (matches alu inA/inB/rslt).
- OPW, 3, ALUOp width.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset (0 = reset).
- r0_valid  input  1  requester 0 has an operation.
- r0_ready  output  1  requester 0 accepted this cycle.
- r0_op  input  OPW  requester 0 ALUOp.
- r0_a, r0_b  input  DW each  requester 0 operands.
- r1_valid, r1_ready, r1_op, r1_a, r1_b  same as r0 for requester 1.
- alu_op  output  OPW  to alu ALUOp.
- alu_a, alu_b  output  DW each  to alu inA/inB.
- alu_rslt  input  DW  from alu rslt.
- alu_taken  input  1  from alu taken.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.
- resp_id  output  1  requester that issued the op (0/1).
- resp_rslt  output  DW  captured result.
- resp_taken  output  1  captured taken flag.
- resp_err  output  1  illegal-op flag (optional feature only; otherwise 0).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: alu_op/alu_a/alu_b = 0; resp_valid = 0; resp_id/resp_rslt/resp_taken/resp_err = 0; busy = 0; priority pointer = 0 (r0 favoured).
- IDLE:
  - Grant is combinational from the valids and the pointer.
  - Only one valid: that requester wins.
  - Both valid: the requester equal to the pointer wins.
  - Winner's rN_ready = 1 in the same cycle (both readys are 0 outside IDLE; the loser's ready is 0).
  - On accept, register op/a/b into alu_op/alu_a/alu_b, record the id, set pointer = ~id, and go to EXEC.
  - No valid: remain in IDLE; alu_* outputs hold their last values.
- EXEC (1 cycle):
  - alu_* outputs are stable.
  - Register alu_rslt into resp_rslt, alu_taken into resp_taken, id into resp_id.
  - Go to RESP.
- RESP:
  - resp_valid = 1; all resp_* outputs held stable until resp_valid && resp_ready.
  - On that handshake, go to IDLE and deassert resp_valid on the next cycle.
  - No new request is accepted in the handshake cycle.
- Latency and throughput:
  - Accept at cycle T → resp_valid first high at T+2.
  - Minimum issue interval is 3 cycles with resp_ready tied high.
- Requesters must hold valid/op/a/b stable until ready; a valid dropped before ready is simply not served.
- Reset asserted mid-operation (any state): the in-flight op is discarded, no response is produced, all registers return to reset values on that edge.
- Fairness: with both requesters continuously valid, grants alternate r0, r1, r0, …

Optional Feature:
- Macro: ALU_OPCHECK_EN.
- Defined:
  - In IDLE, accepted ops 3'b000, 3'b110, 3'b111 are illegal.
  - An illegal op is accepted normally (ready pulses, pointer flips), but alu_* outputs are not updated.
  - FSM goes directly to RESP with resp_rslt = 0, resp_taken = 0, resp_err = 1 (latency T+1).
  - Legal ops give resp_err = 0.
- Undefined:
  - resp_err tied 0; all opcodes are issued to the alu unchanged.

Test Plan:
- Reset, then r0 op=001 a=0xA0 b=0x06, resp_ready=1 → r0_ready at T; alu_op=001, alu_a=0xA0, alu_b=0x06 during EXEC; at T+2 resp_valid=1, resp_id=0, resp_rslt/resp_taken equal the alu model for (001,0xA0,0x06).
- Both valid every cycle: r0 (010,0x11,0x90) and r1 (011,0x01,0x00) → grants r0, r1, r0 in that order; resp_id sequence 0, 1, 0; each response matches its own operands.
- resp_ready held 0 for 5 cycles in RESP → resp_valid stays 1 with constant outputs; r0/r1 ready stay 0; busy=1; one cycle after resp_ready=1 the FSM returns to IDLE.
- Reset driven low during EXEC of r1 (100,0x11,0x90) → next cycle resp_valid=0, busy=0, pointer=0; subsequent simultaneous r0/r1 request grants r0.
- Only r1 valid while pointer=0 → r1 granted immediately; pointer becomes 0.
- With ALU_OPCHECK_EN: r0 op=111 → resp_valid at T+1 with resp_err=1, resp_rslt=0, alu_op unchanged; op=101 a=0 b=0 → resp_err=0, normal T+2 response.
